// File: rtl/vector_dmem_loader_if.sv
// Host byte stream plus vector data-memory write port of the loader.
//   in_valid/in_data/in_ready : byte handshake from the host
//   mem_wr_enable/wr_addr     : one-cycle write strobe and address
//   wd1..wd4                  : four 32-bit lane words of the written vector
// slave  : the loader side (consumes bytes, drives the write port)
// master : the host / memory side
interface vector_dmem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_wr_enable;
  logic [31:0] wr_addr;
  logic [31:0] wd1;
  logic [31:0] wd2;
  logic [31:0] wd3;
  logic [31:0] wd4;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr_enable, wr_addr, wd1, wd2, wd3, wd4
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr_enable, wr_addr, wd1, wd2, wd3, wd4
  );
endinterface

// File: rtl/vector_dmem_loader.sv
// Vector data-memory loader: packs a host byte stream into 4 x 32-bit
// vectors (16 bytes each, lane 1 first, little-endian inside a lane) and
// writes one vector per cycle-long strobe, holding the vector CPU in reset
// until the requested number of vectors has been written.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : one-cycle load request, honoured only in IDLE
//   base_addr : first write address, captured with an accepted start
//   num_vec   : number of vectors to load, captured with an accepted start
//   bus       : byte handshake and write port (slave side)
//   busy      : high while filling or writing
//   done      : one-cycle pulse at the end of a load
//   cpu_hold  : high keeps the vector CPU in reset
module vector_dmem_loader #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_W-1:0]     num_vec,
  vector_dmem_loader_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 cpu_hold
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [3:0]       byte_idx_r;
  logic [CNT_W-1:0] remaining_r;
  logic [31:0]      wr_addr_r;
  logic [31:0]      lane_r [4];
  logic             in_ready_r;
  logic             mem_wr_enable_r;
  logic             busy_r;
  logic             done_r;
  logic             cpu_hold_r;
  logic             accept_s;
  logic             start_load_s;

  assign accept_s     = bus.in_valid & in_ready_r;
  assign start_load_s = (state_r == S_IDLE) & start & (num_vec != {CNT_W{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (num_vec != {CNT_W{1'b0}}) begin
            state_next_s = S_FILL;
          end else begin
            state_next_s = S_DONE;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FILL: begin
        if (accept_s && (byte_idx_r == 4'd15)) begin
          state_next_s = S_WRITE;
        end else begin
          state_next_s = S_FILL;
        end
      end
      S_WRITE: begin
        if (remaining_r == CNT_W'(1)) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_FILL;
        end
      end
      S_DONE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Output flags decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r      <= 1'b0;
      mem_wr_enable_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      cpu_hold_r      <= 1'b1;
    end else begin
      in_ready_r      <= (state_next_s == S_FILL);
      mem_wr_enable_r <= (state_next_s == S_WRITE);
      busy_r          <= (state_next_s == S_FILL) || (state_next_s == S_WRITE);
      done_r          <= (state_next_s == S_DONE);
      // Any accepted start (including zero length) re-asserts the hold; DONE releases it.
      if ((state_r == S_IDLE) && start) begin
        cpu_hold_r <= 1'b1;
      end else if (state_r == S_DONE) begin
        cpu_hold_r <= 1'b0;
      end else begin
        cpu_hold_r <= cpu_hold_r;
      end
    end
  end

  // Datapath: address/count capture, byte packing, and post-write bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_r  <= 4'd0;
      remaining_r <= {CNT_W{1'b0}};
      wr_addr_r   <= 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
        lane_r[i] <= 32'h0000_0000;
      end
    end else if (start_load_s) begin
      wr_addr_r   <= base_addr;
      remaining_r <= num_vec;
      byte_idx_r  <= 4'd0;
    end else if ((state_r == S_FILL) && accept_s) begin
      // byte b lands in lane b/4, byte slot b%4; the index wraps to 0 after byte 15
      lane_r[byte_idx_r[3:2]][{byte_idx_r[1:0], 3'b000} +: 8] <= bus.in_data;
      byte_idx_r <= byte_idx_r + 4'd1;
    end else if (state_r == S_WRITE) begin
      wr_addr_r   <= wr_addr_r + 32'(ADDR_STEP);
      remaining_r <= remaining_r - CNT_W'(1);
      byte_idx_r  <= 4'd0;
    end else begin
      byte_idx_r  <= byte_idx_r;
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.mem_wr_enable = mem_wr_enable_r;
  assign bus.wr_addr       = wr_addr_r;
  assign bus.wd1           = lane_r[0];
  assign bus.wd2           = lane_r[1];
  assign bus.wd3           = lane_r[2];
  assign bus.wd4           = lane_r[3];
  assign busy              = busy_r;
  assign done              = done_r;
  assign cpu_hold          = cpu_hold_r;

endmodule

// File: tb/tb_vector_dmem_loader.sv
// Scoreboard bench for vector_dmem_loader: stimulus pushes the expected
// write (address + lanes) into a queue, a negedge monitor pops and compares
// on every mem_wr_enable pulse.
module tb_vector_dmem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_vec;
  logic        busy;
  logic        done;
  logic        cpu_hold;

  vector_dmem_loader_if bus ();

  vector_dmem_loader #(.ADDR_STEP(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_vec   (num_vec),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [31:0] w4;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks   = 0;
  int  n_fail     = 0;
  int  writes_seen = 0;
  int  writes_exp  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each write against the scoreboard head.
  always @(negedge clk) begin
    if (bus.mem_wr_enable === 1'b1) begin
      writes_seen++;
      check("in_ready_in_write", 64'(bus.in_ready), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h, expected no write", bus.wr_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        check("wd1", 64'(bus.wd1), 64'(e.w1));
        check("wd2", 64'(bus.wd2), 64'(e.w2));
        check("wd3", 64'(bus.wd3), 64'(e.w3));
        check("wd4", 64'(bus.wd4), 64'(e.w4));
      end
    end
    if (done === 1'b1) begin
      check("hold_during_done", 64'(cpu_hold), 64'd1);
      check("busy_during_done", 64'(busy), 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_of(input int seed, input int i);
    return 8'(seed + i * 7);
  endfunction

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4);
    wr_t e;
    e.addr = addr; e.w1 = w1; e.w2 = w2; e.w3 = w3; e.w4 = w4;
    exp_q.push_back(e);
    writes_exp++;
  endtask

  // Expected lanes built independently from the byte list.
  task automatic push_seed(input logic [31:0] addr, input int seed);
    logic [31:0] w [4];
    for (int l = 0; l < 4; l++)
      w[l] = {byte_of(seed, 4*l+3), byte_of(seed, 4*l+2), byte_of(seed, 4*l+1), byte_of(seed, 4*l)};
    push_exp(addr, w[0], w[1], w[2], w[3]);
  endtask

  // Called and returns on a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_seed(input int seed, input int gap_mode);
    for (int i = 0; i < 16; i++)
      send_byte(byte_of(seed, i), (gap_mode == 0) ? 0 : ((i * 3 + seed) % 4));
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] n);
    start     = 1'b1;
    base_addr = base;
    num_vec   = n;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_pulse"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, "_done_low"}, 64'(done), 64'd0);
    check({tag, "_hold_released"}, 64'(cpu_hold), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = 32'h0; num_vec = 16'h0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_wr_en", 64'(bus.mem_wr_enable), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold", 64'(cpu_hold), 64'd1);
    check("idle_ready", 64'(bus.in_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Single vector, bytes 0x00..0x0F back to back.
    push_exp(32'h0000_0100, 32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C);
    do_start(32'h0000_0100, 16'd1);
    check("fill_busy", 64'(busy), 64'd1);
    check("fill_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    check("write_latency", 64'(bus.mem_wr_enable), 64'd1);
    wait_done("single");

    // Three vectors with in_valid gaps.
    push_seed(32'h0000_0000, 17);
    push_seed(32'h0000_0004, 41);
    push_seed(32'h0000_0008, 99);
    do_start(32'h0000_0000, 16'd3);
    send_seed(17, 1);
    send_seed(41, 1);
    send_seed(99, 1);
    wait_done("three");

    // Address wrap.
    push_seed(32'hFFFF_FFFC, 3);
    push_seed(32'h0000_0000, 200);
    do_start(32'hFFFF_FFFC, 16'd2);
    send_seed(3, 0);
    send_seed(200, 1);
    wait_done("wrap");

    // Zero length.
    do_start(32'h0000_0055, 16'd0);
    wait_done("zero");

    // Abort mid second vector, then a clean reload.
    push_seed(32'h0000_0200, 5);
    do_start(32'h0000_0200, 16'd3);
    send_seed(5, 0);
    for (int i = 0; i < 7; i++) send_byte(byte_of(77, i), 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_hold", 64'(cpu_hold), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", 64'(bus.mem_wr_enable), 64'd0);
    push_seed(32'h0000_0300, 123);
    do_start(32'h0000_0300, 16'd1);
    send_seed(123, 1);
    wait_done("reload");

    // start during FILL with a different base is ignored.
    push_seed(32'h0000_0400, 9);
    push_seed(32'h0000_0404, 60);
    do_start(32'h0000_0400, 16'd2);
    for (int i = 0; i < 5; i++) send_byte(byte_of(9, i), 0);
    start = 1'b1; base_addr = 32'h0000_0999; num_vec = 16'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 5; i < 16; i++) send_byte(byte_of(9, i), 0);
    send_seed(60, 0);
    wait_done("ignore_start");

    repeat (5) @(negedge clk);
    check("writes_total", 64'(writes_seen), 64'(writes_exp));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_dmem_loader.md
Name: vector_dmem_loader

Overview:
- Upstream feeder for the vector data memory.
- Accepts a host byte stream over a valid/ready handshake and packs 16 bytes into one 4-lane vector (4 x 32 bit).
- Issues one write per vector on the data-memory write port: enable, address, and four lane words.
- Holds the vector CPU via cpu_hold until the programmed number of vectors is loaded, then releases it and pulses done.

Parameters:
ADDR_STEP, 4, wr_addr increment per written vector.
CNT_W, 16, width of the vector-count input and internal remaining counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; reset is asynchronous and active-low.
start  input  1  one-cycle load request; sampled only in IDLE.
base_addr  input  32  first write address; latched on accepted start.
num_vec  input  CNT_W  vectors to load; latched on accepted start.
in_valid  input  1  host byte valid.
in_data  input  8  host byte.
in_ready  output  1  loader accepts a byte this cycle.
mem_wr_enable  output  1  data-memory write strobe, one cycle per vector.
wr_addr  output  32  data-memory write address.
wd1  output  32  lane 1 write data.
wd2  output  32  lane 2 write data.
wd3  output  32  lane 3 write data.
wd4  output  32  lane 4 write data.
busy  output  1  high in FILL or WRITE.
done  output  1  one-cycle pulse at end of load.
cpu_hold  output  1  high keeps the CPU in reset.

Behaviour:
- Reset (rst=0, asynchronous): enter IDLE. All outputs are 0 except cpu_hold=1. Byte index, remaining counter and lane registers clear. Reset mid-load aborts the load: the partial vector is discarded and no write is issued.
- All outputs are registered. in_ready is a registered state decode: high exactly in FILL.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - start=1 with num_vec!=0: latch base_addr into wr_addr, num_vec into remaining; clear byte index; go to FILL; cpu_hold<=1.
  - start=1 with num_vec==0: go to DONE directly; no writes are issued.
- FILL:
  - Each handshake (in_valid & in_ready) stores in_data at byte index b (0..15): lane = b/4 + 1, bits [8*(b%4)+7 : 8*(b%4)]. Little-endian within a lane; lane 1 is filled first.
  - in_valid=0 stalls with no state change.
  - The 16th accepted byte moves the FSM to WRITE. in_ready is 0 on the following cycle, so no byte is lost or duplicated.
- WRITE (exactly one cycle):
  - mem_wr_enable=1; wr_addr=current address; wd1..wd4 carry the packed lanes.
  - On exit: wr_addr += ADDR_STEP, mod 2^32 with wrap-around; remaining -= 1; byte index cleared.
  - remaining was 1: go to DONE; else go back to FILL.
  - Latency: mem_wr_enable is high the cycle after the 16th byte is accepted.
- DONE (one cycle): done=1; cpu_hold<=0 from the next cycle; return to IDLE.
- cpu_hold is 1 from reset and from accepted start until DONE, and 0 afterwards until the next accepted start.
- busy is 1 in FILL and WRITE, 0 in IDLE and DONE.
- start is ignored outside IDLE, including a start coinciding with the DONE cycle.
- wd1..wd4 hold their lane register values at all times; they are meaningful only while mem_wr_enable=1.
- mem_wr_enable is 0 in every state except WRITE.
- A maximum num_vec (2^CNT_W - 1) loads that many vectors with no counter overflow.

Test Plan:
- Reset state: rst=0 -> cpu_hold=1, in_ready=0, mem_wr_enable=0, done=0, busy=0. Release rst -> state holds until start.
- Single vector: start with base_addr=0x100, num_vec=1; stream bytes 0x00..0x0F with in_valid held 1 ->
  - wd1=0x03020100, wd2=0x07060504, wd3=0x0B0A0908, wd4=0x0F0E0D0C, wr_addr=0x100, one mem_wr_enable pulse;
  - done one cycle later; cpu_hold=0 after.
- Three vectors with random in_valid gaps: base_addr=0x0 -> exactly 3 write pulses at 0x0, 0x4, 0x8; data matches the byte stream; in_ready=0 in each WRITE cycle.
- Wrap and zero length:
  - base_addr=0xFFFFFFFC, num_vec=2 -> writes at 0xFFFFFFFC then 0x00000000.
  - num_vec=0 -> no write; done pulse; cpu_hold=0.
- Abort: assert rst after 7 bytes of the second vector -> no further write; cpu_hold=1. A new start loads cleanly from byte 0.
- start pulsed during FILL with a different base_addr -> ignored; addresses follow the original base.
